// File: rtl/debug_clock_ctrl.sv
// Debug clock-enable generator for the 6502 core: full-speed run, divided run,
// debounced single-step and halt, all as a one-cycle cpu_ce in a single clock domain.
module debug_clock_ctrl #(
  parameter int unsigned          CNT_WIDTH       = 32,
  parameter logic [CNT_WIDTH-1:0] RATE0           = CNT_WIDTH'(1),
  parameter logic [CNT_WIDTH-1:0] RATE1           = CNT_WIDTH'(50_000),
  parameter logic [CNT_WIDTH-1:0] RATE2           = CNT_WIDTH'(5_000_000),
  parameter logic [CNT_WIDTH-1:0] RATE3           = CNT_WIDTH'(25_000_000),
  parameter int unsigned          DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned          CE_CNT_WIDTH    = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic [1:0]              rate_sel,
  input  logic                    step_btn,
  output logic                    cpu_ce,
  output logic                    clk_vis,
  output logic [CE_CNT_WIDTH-1:0] ce_count,
  output logic                    halted
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1 before the level flips.
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_DIV  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_HALT = 2'b11
  } mode_e;

  mode_e                   mode_q, mode_d;
  logic [1:0]              rate_q, rate_d;
  logic [CNT_WIDTH-1:0]    div_cnt_q, div_cnt_d;
  logic                    sync1_q, sync1_d;
  logic                    sync2_q, sync2_d;
  logic [DB_W-1:0]         deb_cnt_q, deb_cnt_d;
  logic                    deb_q, deb_d;
  logic                    deb_rise_q, deb_rise_d;
  logic                    cpu_ce_q, cpu_ce_d;
  logic                    clk_vis_q, clk_vis_d;
  logic [CE_CNT_WIDTH-1:0] ce_count_q, ce_count_d;
  logic                    halted_q, halted_d;

  logic [CNT_WIDTH-1:0]    rate_val;
  logic [CNT_WIDTH-1:0]    div_last;
  logic                    mode_chg;

  // Terminal count of the selected divisor; a zero divisor behaves as one.
  always_comb begin
    case (rate_q)
      2'd0:    rate_val = RATE0;
      2'd1:    rate_val = RATE1;
      2'd2:    rate_val = RATE2;
      default: rate_val = RATE3;
    endcase
    div_last = (rate_val == '0) ? '0 : rate_val - CNT_WIDTH'(1);
  end

  always_comb begin
    mode_d     = mode_e'(mode);
    rate_d     = rate_sel;
    sync1_d    = step_btn;
    sync2_d    = sync1_q;
    deb_cnt_d  = '0;
    deb_d      = deb_q;
    div_cnt_d  = '0;
    cpu_ce_d   = 1'b0;
    mode_chg   = (mode_d != mode_q) || ((mode_q == MODE_DIV) && (rate_d != rate_q));

    // Debouncer runs in every mode; only STEP turns a rising level into a pulse.
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DB_W'(1);
      end
    end
    deb_rise_d = deb_d & ~deb_q;

    // A mode or rate change clears the divider and suppresses any coinciding pulse.
    if (!mode_chg) begin
      case (mode_q)
        MODE_RUN:  cpu_ce_d = 1'b1;
        MODE_DIV: begin
          if (div_cnt_q >= div_last) begin
            cpu_ce_d = 1'b1;
          end else begin
            div_cnt_d = div_cnt_q + CNT_WIDTH'(1);
          end
        end
        MODE_STEP: cpu_ce_d = deb_rise_q;
        default:   cpu_ce_d = 1'b0;
      endcase
    end

    clk_vis_d  = clk_vis_q ^ cpu_ce_q;
    ce_count_d = ce_count_q + CE_CNT_WIDTH'(cpu_ce_q);
    halted_d   = (mode_d == MODE_HALT);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_RUN;
      rate_q     <= 2'd0;
      div_cnt_q  <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_cnt_q  <= '0;
      deb_q      <= 1'b0;
      deb_rise_q <= 1'b0;
      cpu_ce_q   <= 1'b0;
      clk_vis_q  <= 1'b0;
      ce_count_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      rate_q     <= rate_d;
      div_cnt_q  <= div_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_cnt_q  <= deb_cnt_d;
      deb_q      <= deb_d;
      deb_rise_q <= deb_rise_d;
      cpu_ce_q   <= cpu_ce_d;
      clk_vis_q  <= clk_vis_d;
      ce_count_q <= ce_count_d;
      halted_q   <= halted_d;
    end
  end

  assign cpu_ce   = cpu_ce_q;
  assign clk_vis  = clk_vis_q;
  assign ce_count = ce_count_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_debug_clock_ctrl.sv
// Bench for debug_clock_ctrl: directed scenarios plus random mode/button traffic,
// all checked against a cycle-level behavioural model kept here.
module tb_debug_clock_ctrl;

  localparam int unsigned D = 4;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [1:0] rate_sel;
  logic       step_btn;
  logic       cpu_ce;
  logic       clk_vis;
  logic [3:0] ce_count;
  logic       halted;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  debug_clock_ctrl #(
    .CNT_WIDTH(32), .RATE0(32'd1), .RATE1(32'd5), .RATE2(32'd3), .RATE3(32'd0),
    .DEBOUNCE_CYCLES(D), .CE_CNT_WIDTH(4)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .mode(mode), .rate_sel(rate_sel),
    .step_btn(step_btn), .cpu_ce(cpu_ce), .clk_vis(clk_vis),
    .ce_count(ce_count), .halted(halted)
  );

  // Effective divisors of this instance; RATE3=0 counts as 1.
  function automatic int unsigned rate_n(input logic [1:0] r);
    case (r)
      2'd0:    return 1;
      2'd1:    return 5;
      2'd2:    return 3;
      default: return 1;
    endcase
  endfunction

  // Reference model: pulses at multiples of N edges since the last clear; the
  // debounced level flips once the last D synchronised samples all disagree with it.
  logic [1:0]  m_mode, m_rate;
  int unsigned m_since;
  logic        m_ce, m_vis, m_halt, m_deb, m_rose;
  logic [3:0]  m_cnt;
  logic [D:0]  m_hist;
  wire         m_chg  = (mode != m_mode) || ((m_mode == 2'd1) && (rate_sel != m_rate));
  wire         m_flip = (m_hist[D:1] == {D{~m_deb}});

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 2'd0; m_rate <= 2'd0; m_since <= 0;
      m_ce <= 1'b0; m_vis <= 1'b0; m_halt <= 1'b0; m_cnt <= 4'd0;
      m_deb <= 1'b0; m_rose <= 1'b0; m_hist <= '0;
    end else begin
      m_mode  <= mode;
      m_rate  <= rate_sel;
      m_halt  <= (mode == 2'd3);
      m_since <= m_chg ? 0 : m_since + 1;
      m_ce    <= !m_chg && ((m_mode == 2'd0) ||
                 ((m_mode == 2'd1) && (((m_since + 1) % rate_n(m_rate)) == 0)) ||
                 ((m_mode == 2'd2) && m_rose));
      m_vis   <= m_vis ^ m_ce;
      m_cnt   <= m_cnt + 4'(m_ce);
      m_hist  <= {m_hist[D-1:0], step_btn};
      m_deb   <= m_flip ? ~m_deb : m_deb;
      m_rose  <= m_flip && !m_deb;
    end
  end

  task automatic test_reset();
    mode = 2'd0; rate_sel = 2'd0; step_btn = 1'b0; rst_n = 1'b0;
    @(negedge clk_in);
    total++;
    if ({cpu_ce, clk_vis, ce_count, halted} !== 7'b0) begin
      bad++; $display("FAIL reset_state got=%b exp=%b", {cpu_ce, clk_vis, ce_count, halted}, 7'b0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_run();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_in);
      total++;
      if (cpu_ce !== 1'b1) begin bad++; $display("FAIL run_ce k=%0d got=%b exp=1", k, cpu_ce); end
      total++;
      if ({cpu_ce, clk_vis, ce_count, halted} !== {m_ce, m_vis, m_cnt, m_halt}) begin
        bad++; $display("FAIL run_model k=%0d got=%b exp=%b", k, {cpu_ce, clk_vis, ce_count, halted}, {m_ce, m_vis, m_cnt, m_halt});
      end
    end
    @(negedge clk_in);
    total++;
    if (ce_count !== 4'd10) begin bad++; $display("FAIL run_count got=%0d exp=10", ce_count); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({cpu_ce, clk_vis, ce_count, halted} !== 7'b0) begin
      bad++; $display("FAIL run_async_reset got=%b exp=%b", {cpu_ce, clk_vis, ce_count, halted}, 7'b0);
    end
  endtask

  task automatic test_div();
    @(negedge clk_in);
    rst_n = 1'b1; mode = 2'd1; rate_sel = 2'd1;
    @(negedge clk_in);  // clear edge
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk_in);
      total++;
      if (cpu_ce !== ((j <= 12) ? (j % 5 == 0) : (j >= 14))) begin
        bad++; $display("FAIL div_ce j=%0d got=%b exp=%b", j, cpu_ce, (j <= 12) ? (j % 5 == 0) : (j >= 14));
      end
      total++;
      if ({cpu_ce, clk_vis, ce_count, halted} !== {m_ce, m_vis, m_cnt, m_halt}) begin
        bad++; $display("FAIL div_model j=%0d got=%b exp=%b", j, {cpu_ce, clk_vis, ce_count, halted}, {m_ce, m_vis, m_cnt, m_halt});
      end
      if (j == 12) rate_sel = 2'd0;
    end
  endtask

  task automatic test_step();
    logic [3:0] cnt0;
    mode = 2'd2;
    repeat (4) @(negedge clk_in);
    cnt0 = ce_count;
    step_btn = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_in);
      total++;
      if (cpu_ce !== (k == 7)) begin bad++; $display("FAIL step_ce k=%0d got=%b exp=%b", k, cpu_ce, (k == 7)); end
      total++;
      if ({cpu_ce, clk_vis, ce_count, halted} !== {m_ce, m_vis, m_cnt, m_halt}) begin
        bad++; $display("FAIL step_model k=%0d got=%b exp=%b", k, {cpu_ce, clk_vis, ce_count, halted}, {m_ce, m_vis, m_cnt, m_halt});
      end
      if (k == 20) begin
        total++;
        if (ce_count !== cnt0 + 4'd1) begin bad++; $display("FAIL step_count got=%0d exp=%0d", ce_count, cnt0 + 4'd1); end
        step_btn = 1'b0;
      end
    end
  endtask

  task automatic test_glitch_halt();
    int pulses;
    pulses = 0;
    // Three short glitches, then a press held through HALT into STEP, then release.
    for (int k = 0; k < 52; k++) begin
      if (k < 18)       step_btn = ((k % 6) < 3);
      else if (k == 26) begin mode = 2'd3; step_btn = 1'b1; end
      else if (k == 38) mode = 2'd2;
      @(negedge clk_in);
      pulses += int'(cpu_ce);
      total++;
      if ({cpu_ce, clk_vis, ce_count, halted} !== {m_ce, m_vis, m_cnt, m_halt}) begin
        bad++; $display("FAIL glitch_model k=%0d got=%b exp=%b", k, {cpu_ce, clk_vis, ce_count, halted}, {m_ce, m_vis, m_cnt, m_halt});
      end
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL glitch_pulses got=%0d exp=0", pulses); end
    step_btn = 1'b0;
    repeat (10) @(negedge clk_in);
    step_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_in);
      total++;
      if (cpu_ce !== (k == 7)) begin bad++; $display("FAIL repress_ce k=%0d got=%b exp=%b", k, cpu_ce, (k == 7)); end
    end
    step_btn = 1'b0;
    repeat (8) @(negedge clk_in);
  endtask

  task automatic test_halt_div();
    mode = 2'd1; rate_sel = 2'd1;
    repeat (8) @(negedge clk_in);
    mode = 2'd3;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_in);
      total++;
      if ({cpu_ce, halted} !== 2'b01) begin bad++; $display("FAIL halt_state k=%0d got=%b exp=01", k, {cpu_ce, halted}); end
    end
    mode = 2'd1;
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk_in);
      total++;
      if ({cpu_ce, halted} !== {(j == 5), 1'b0}) begin
        bad++; $display("FAIL halt_div j=%0d got=%b exp=%b", j, {cpu_ce, halted}, {(j == 5), 1'b0});
      end
      total++;
      if ({cpu_ce, clk_vis, ce_count, halted} !== {m_ce, m_vis, m_cnt, m_halt}) begin
        bad++; $display("FAIL halt_model j=%0d got=%b exp=%b", j, {cpu_ce, clk_vis, ce_count, halted}, {m_ce, m_vis, m_cnt, m_halt});
      end
    end
  endtask

  task automatic test_wrap();
    mode = 2'd0; rate_sel = 2'd0; step_btn = 1'b0; rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk_in);
      total++;
      if (ce_count !== 4'(k - 1)) begin bad++; $display("FAIL wrap_count k=%0d got=%0d exp=%0d", k, ce_count, 4'(k - 1)); end
    end
  endtask

  task automatic test_random();
    int hold_m, hold_b;
    hold_m = 0; hold_b = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_in);
      total++;
      if ({cpu_ce, clk_vis, ce_count, halted} !== {m_ce, m_vis, m_cnt, m_halt}) begin
        bad++; $display("FAIL rand_model c=%0d got=%b exp=%b", c, {cpu_ce, clk_vis, ce_count, halted}, {m_ce, m_vis, m_cnt, m_halt});
      end
      if (hold_m == 0) begin
        mode = 2'($urandom_range(0, 3));
        rate_sel = 2'($urandom_range(0, 3));
        hold_m = int'($urandom_range(1, 25));
      end else begin
        hold_m--;
        if ($urandom_range(0, 15) == 0) rate_sel = 2'($urandom_range(0, 3));
      end
      if (hold_b == 0) begin
        step_btn = ~step_btn;
        hold_b = int'($urandom_range(1, 9));
      end else begin
        hold_b--;
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_div();
    test_step();
    test_glitch_halt();
    test_halt_div();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
